// File: rtl/a2d_pkg.sv
// Shared types and constants for the A2D scan sequencer.
package a2d_pkg;

    localparam int NUM_SLOTS = 4;

    typedef logic [11:0] a2d_res_t;

    typedef enum logic [2:0] {
        IDLE,
        SLOT_START,
        SLOT_WAIT,
        DMD_START,
        DMD_WAIT
    } scan_state_t;

endpackage

// File: rtl/a2d_period_tmr.sv
// Scan period counter: free-runs while en, pulses tick on the last count.
module a2d_period_tmr #(
    parameter logic [19:0] SCAN_PERIOD = 20'd1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    logic [19:0] count;

    assign tick = en && (count == SCAN_PERIOD - 20'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!en || tick) begin
            count <= '0;
        end else begin
            count <= count + 20'd1;
        end
    end

endmodule

// File: rtl/a2d_scan_ctrl.sv
// Owns the A2D handshake: periodic four-slot IR scan plus one-shot demand
// conversions slotted between scan slots, with a per-conversion timeout.
//
// state      | meaning
// IDLE       | no conversion in flight; waiting for demand or scan tick
// SLOT_START | strt_cnv issued for current scan slot
// SLOT_WAIT  | waiting for cnv_cmplt of scan slot
// DMD_START  | strt_cnv issued for latched demand channel
// DMD_WAIT   | waiting for cnv_cmplt of demand conversion
module a2d_scan_ctrl
    import a2d_pkg::*;
#(
    parameter logic [19:0] SCAN_PERIOD = 20'd1_000_000,
    parameter logic [2:0]  CH0         = 3'd0,
    parameter logic [2:0]  CH1         = 3'd4,
    parameter logic [2:0]  CH2         = 3'd3,
    parameter logic [2:0]  CH3         = 3'd7,
    parameter logic [11:0] TIMEOUT     = 12'd2048,
    parameter logic        INVERT      = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        rd_req,
    input  logic [2:0]  rd_chnnl,
    output logic        rd_busy,
    output logic        rd_rdy,
    output logic [11:0] rd_res,
    output logic        strt_cnv,
    output logic [2:0]  chnnl,
    input  logic        cnv_cmplt,
    input  logic [11:0] res,
    output logic [11:0] ir0,
    output logic [11:0] ir1,
    output logic [11:0] ir2,
    output logic [11:0] ir3,
    output logic        scan_done,
    output logic        overrun,
    output logic        tmo_err,
    input  logic        clr_err
);

    scan_state_t state;
    a2d_res_t    ir_q [NUM_SLOTS];
    logic [1:0]  slot;
    logic [2:0]  dmd_ch;
    logic        pending;
    logic        in_scan;
    logic        tick_hold;
    logic [11:0] wait_cnt;
    logic        tick;
    logic        accept;
    logic        dmd_go;

    a2d_period_tmr #(.SCAN_PERIOD(SCAN_PERIOD)) u_tmr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .tick  (tick)
    );

    function automatic logic [2:0] slot_ch(input logic [1:0] s);
        case (s)
            2'd0:    return CH0;
            2'd1:    return CH1;
            2'd2:    return CH2;
            default: return CH3;
        endcase
    endfunction

    assign accept  = rd_req && !pending;
    // An idle request is launched on the very next edge, before pending is visible.
    assign dmd_go  = pending || accept;
    assign rd_busy = pending;
    assign ir0 = ir_q[0];
    assign ir1 = ir_q[1];
    assign ir2 = ir_q[2];
    assign ir3 = ir_q[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            for (int i = 0; i < NUM_SLOTS; i++) ir_q[i] <= '0;
            slot      <= '0;
            dmd_ch    <= '0;
            pending   <= 1'b0;
            in_scan   <= 1'b0;
            tick_hold <= 1'b0;
            wait_cnt  <= 12'd1;
            strt_cnv  <= 1'b0;
            chnnl     <= '0;
            rd_rdy    <= 1'b0;
            rd_res    <= '0;
            scan_done <= 1'b0;
            overrun   <= 1'b0;
            tmo_err   <= 1'b0;
        end else begin
            strt_cnv  <= 1'b0;
            rd_rdy    <= 1'b0;
            scan_done <= 1'b0;

            if (accept) begin
                pending <= 1'b1;
                dmd_ch  <= rd_chnnl;
            end

            // Ticks outside a scan are remembered; the scan start below clears the memory.
            if (tick) begin
                if (in_scan) overrun   <= 1'b1;
                else         tick_hold <= 1'b1;
            end

            if (state == SLOT_WAIT || state == DMD_WAIT) wait_cnt <= wait_cnt + 12'd1;
            else                                         wait_cnt <= 12'd1;

            case (state)
                IDLE: begin
                    if (dmd_go) begin
                        state    <= DMD_START;
                        strt_cnv <= 1'b1;
                        chnnl    <= pending ? dmd_ch : rd_chnnl;
                    end else if (tick || tick_hold) begin
                        state     <= SLOT_START;
                        strt_cnv  <= 1'b1;
                        chnnl     <= CH0;
                        slot      <= 2'd0;
                        in_scan   <= 1'b1;
                        tick_hold <= 1'b0;
                    end
                end
                SLOT_START: state <= SLOT_WAIT;
                SLOT_WAIT: begin
                    if (cnv_cmplt) begin
                        ir_q[slot] <= INVERT ? ~res : res;
                        if (slot == 2'd3) begin
                            scan_done <= 1'b1;
                            in_scan   <= 1'b0;
                            state     <= IDLE;
                        end else if (pending) begin
                            state    <= DMD_START;
                            strt_cnv <= 1'b1;
                            chnnl    <= dmd_ch;
                        end else begin
                            slot     <= slot + 2'd1;
                            state    <= SLOT_START;
                            strt_cnv <= 1'b1;
                            chnnl    <= slot_ch(slot + 2'd1);
                        end
                    end else if (wait_cnt == TIMEOUT) begin
                        tmo_err <= 1'b1;
                        in_scan <= 1'b0;
                        state   <= IDLE;
                    end
                end
                DMD_START: state <= DMD_WAIT;
                DMD_WAIT: begin
                    if (cnv_cmplt || wait_cnt == TIMEOUT) begin
                        rd_res  <= cnv_cmplt ? res : 12'hFFF;
                        tmo_err <= tmo_err | !cnv_cmplt;
                        rd_rdy  <= 1'b1;
                        pending <= 1'b0;
                        if (in_scan) begin
                            slot     <= slot + 2'd1;
                            state    <= SLOT_START;
                            strt_cnv <= 1'b1;
                            chnnl    <= slot_ch(slot + 2'd1);
                        end else if (tick || tick_hold) begin
                            state     <= SLOT_START;
                            strt_cnv  <= 1'b1;
                            chnnl     <= CH0;
                            slot      <= 2'd0;
                            in_scan   <= 1'b1;
                            tick_hold <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (clr_err) begin
                overrun <= 1'b0;
                tmo_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_a2d_scan_ctrl.sv
// Directed bench for a2d_scan_ctrl with a behavioural A2D interface model.
module tb_a2d_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        rd_req = 1'b0;
    logic [2:0]  rd_chnnl = '0;
    logic        clr_err = 1'b0;
    logic        cnv_cmplt = 1'b0;
    logic [11:0] res = '0;
    logic        rd_busy, rd_rdy, strt_cnv, scan_done, overrun, tmo_err;
    logic [11:0] rd_res, ir0, ir1, ir2, ir3;
    logic [2:0]  chnnl;

    a2d_scan_ctrl #(.SCAN_PERIOD(20'd200), .TIMEOUT(12'd64)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rd_req(rd_req), .rd_chnnl(rd_chnnl),
        .rd_busy(rd_busy), .rd_rdy(rd_rdy), .rd_res(rd_res), .strt_cnv(strt_cnv),
        .chnnl(chnnl), .cnv_cmplt(cnv_cmplt), .res(res), .ir0(ir0), .ir1(ir1),
        .ir2(ir2), .ir3(ir3), .scan_done(scan_done), .overrun(overrun),
        .tmo_err(tmo_err), .clr_err(clr_err)
    );

    always #10 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // A2D model: completes lat clocks after strt_cnv unless the channel hangs.
    logic [11:0] res_tab [8];
    int          lat = 40;
    int          hang_ch = -1;
    int          cnt = 0;
    logic [2:0]  cur_ch = '0;
    always @(negedge clk) begin
        cnv_cmplt = 1'b0;
        if (strt_cnv) begin
            cur_ch = chnnl;
            cnt = (int'(chnnl) == hang_ch) ? 0 : lat;
        end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                cnv_cmplt = 1'b1;
                res = res_tab[cur_ch];
            end
        end
    end

    logic [2:0] strt_ch [$];
    int         strt_cyc [$];
    int         n_done = 0;
    int         n_rdy = 0;
    always @(negedge clk) begin
        if (strt_cnv) begin
            strt_ch.push_back(chnnl);
            strt_cyc.push_back(cyc);
        end
        if (scan_done) n_done++;
        if (rd_rdy) n_rdy++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    logic [2:0] seq_exp [$];
    task automatic chk_seq(input string nm);
        chk({nm, "_len"}, strt_ch.size(), seq_exp.size());
        for (int i = 0; i < seq_exp.size(); i++)
            if (i < strt_ch.size()) chk(nm, {29'd0, strt_ch[i]}, {29'd0, seq_exp[i]});
    endtask

    // which: 0 = rd_rdy, 1 = scan_done, 2 = strt_cnv, 3 = overrun
    task automatic wait_ev(input int which, input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk); #1;
            if ((which == 0 && rd_rdy) || (which == 1 && scan_done) ||
                (which == 2 && strt_cnv) || (which == 3 && overrun)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [11:0] get_ir(input int i);
        case (i)
            0:       return ir0;
            1:       return ir1;
            2:       return ir2;
            default: return ir3;
        endcase
    endfunction

    task automatic pulse_clr();
        @(posedge clk); #1 clr_err = 1'b1;
        @(posedge clk); #1 clr_err = 1'b0;
    endtask

    typedef struct { logic [2:0] ch; logic [11:0] val; bit hang; logic [11:0] exp; } dmd_vec_t;
    typedef struct { logic [2:0] ch; logic [11:0] raw; logic [11:0] ir; } slot_vec_t;
    dmd_vec_t dv [4];
    slot_vec_t sv [4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int k;
        int t0;

        for (int i = 0; i < 8; i++) res_tab[i] = 12'h000;
        dv[0] = '{3'd5, 12'h9C4, 1'b0, 12'h9C4};
        dv[1] = '{3'd1, 12'h3A7, 1'b0, 12'h3A7};
        dv[2] = '{3'd6, 12'h456, 1'b0, 12'h456};
        dv[3] = '{3'd2, 12'h555, 1'b1, 12'hFFF};
        sv[0] = '{3'd0, 12'h0F0, 12'hF0F};
        sv[1] = '{3'd4, 12'h0A5, 12'hF5A};
        sv[2] = '{3'd3, 12'h123, 12'hEDC};
        sv[3] = '{3'd7, 12'h800, 12'h7FF};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); #1;
        chk("rst_strt", strt_cnv, 0);
        chk("rst_busy", rd_busy, 0);
        chk("rst_flags", {overrun, tmo_err, scan_done, rd_rdy}, 0);
        chk("rst_ir", {ir0, ir1, ir2, ir3}, 0);
        chk("rst_chnnl", chnnl, 0);

        // Demand conversions from IDLE, last one hangs and times out.
        for (int v = 0; v < 4; v++) begin
            res_tab[dv[v].ch] = dv[v].val;
            hang_ch = dv[v].hang ? int'(dv[v].ch) : -1;
            @(posedge clk); #1 rd_req = 1'b1; rd_chnnl = dv[v].ch;
            @(posedge clk); #1 rd_req = 1'b0;
            @(negedge clk); #1;
            chk("dmd_strt", strt_cnv, 1);
            chk("dmd_chnnl", chnnl, dv[v].ch);
            chk("dmd_busy", rd_busy, 1);
            wait_ev(0, 120, ok);
            chk("dmd_rdy_seen", ok, 1);
            chk("dmd_res", rd_res, dv[v].exp);
            chk("dmd_busy_clr", rd_busy, 0);
            repeat (3) @(posedge clk);
        end
        hang_ch = -1;
        @(negedge clk); #1;
        chk("dmd_tmo_err", tmo_err, 1);
        pulse_clr();
        @(negedge clk); #1;
        chk("clr_tmo", tmo_err, 0);

        // Basic periodic scan.
        for (int i = 0; i < 4; i++) res_tab[sv[i].ch] = sv[i].raw;
        strt_ch.delete(); strt_cyc.delete(); n_done = 0;
        @(posedge clk); #1 en = 1'b1;
        wait_ev(1, 500, ok);
        chk("scan_done_seen", ok, 1);
        seq_exp = '{3'd0, 3'd4, 3'd3, 3'd7};
        chk_seq("scan_order");
        for (int i = 0; i < 4; i++) chk("scan_ir", get_ir(i), sv[i].ir);
        t0 = strt_cyc.size() > 0 ? strt_cyc[0] : 0;
        wait_ev(2, 300, ok);
        chk("period", strt_cyc.size() > 4 ? strt_cyc[4] - t0 : 0, 200);
        @(posedge clk); #1 en = 1'b0;
        wait_ev(1, 300, ok);
        chk("en_off_finish", ok, 1);
        chk("scan_done_cnt", n_done, 2);
        chk("no_overrun", overrun, 0);
        repeat (10) @(posedge clk);

        // Demand slotted into a running scan; second request while busy is dropped.
        strt_ch.delete(); n_done = 0; n_rdy = 0;
        @(posedge clk); #1 en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            if (strt_cnv && chnnl == 3'd4) break;
        end
        @(posedge clk); #1 rd_req = 1'b1; rd_chnnl = 3'd6;
        @(posedge clk); #1 rd_req = 1'b0;
        repeat (3) @(posedge clk);
        #1 rd_req = 1'b1; rd_chnnl = 3'd2; en = 1'b0;
        @(posedge clk); #1 rd_req = 1'b0;
        wait_ev(1, 600, ok);
        chk("mid_done_seen", ok, 1);
        repeat (60) @(posedge clk);
        seq_exp = '{3'd0, 3'd4, 3'd6, 3'd3, 3'd7};
        chk_seq("mid_order");
        chk("mid_rdy_cnt", n_rdy, 1);
        chk("mid_res", rd_res, 12'h456);
        chk("mid_busy", rd_busy, 0);
        chk("mid_overrun", overrun, 0);

        // Demand and scan tick in the same IDLE cycle.
        strt_ch.delete(); n_done = 0; n_rdy = 0;
        @(posedge clk); #1 en = 1'b1;
        repeat (199) @(posedge clk);
        #1 rd_req = 1'b1; rd_chnnl = 3'd5;
        @(posedge clk); #1 rd_req = 1'b0; en = 1'b0;
        wait_ev(1, 600, ok);
        chk("sim_done_seen", ok, 1);
        seq_exp = '{3'd5, 3'd0, 3'd4, 3'd3, 3'd7};
        chk_seq("sim_order");
        chk("sim_rdy_cnt", n_rdy, 1);
        chk("sim_overrun", overrun, 0);
        repeat (10) @(posedge clk);

        // Overrun: 60-clock conversions make a scan longer than the period.
        lat = 60;
        @(posedge clk); #1 en = 1'b1;
        wait_ev(3, 700, ok);
        chk("overrun_set", ok, 1);
        chk("overrun_no_tmo", tmo_err, 0);
        pulse_clr();
        @(negedge clk); #1;
        chk("overrun_clr", overrun, 0);
        @(posedge clk); #1 en = 1'b0;
        wait_ev(1, 400, ok);
        repeat (10) @(posedge clk);

        // Timeout on slot 2: ir2/ir3 keep previous scan values.
        lat = 40; hang_ch = 3;
        res_tab[0] = 12'h111; res_tab[4] = 12'h222;
        strt_ch.delete(); n_done = 0;
        @(posedge clk); #1 en = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk); #1;
            if (strt_cnv && chnnl == 3'd3) break;
        end
        k = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk); #1;
            if (tmo_err) begin k = i; break; end
        end
        chk("tmo_latency", k, 65);
        chk("tmo_ir0", ir0, 12'hEEE);
        chk("tmo_ir1", ir1, 12'hDDD);
        chk("tmo_ir2", ir2, 12'hEDC);
        chk("tmo_ir3", ir3, 12'h7FF);
        hang_ch = -1;
        wait_ev(2, 300, ok);
        chk("tmo_restart_ch", chnnl, 0);
        chk("tmo_no_done", n_done, 0);
        @(posedge clk); #1 en = 1'b0;
        wait_ev(1, 400, ok);
        chk("tmo_next_scan_done", ok, 1);
        seq_exp = '{3'd0, 3'd4, 3'd3, 3'd0, 3'd4, 3'd3, 3'd7};
        chk_seq("tmo_order");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
